// File: rtl/term_inject_bank_pkg.sv
// rtl/term_inject_bank_pkg.sv - shared field layout, types and address screening for term_inject_bank
//
// Purpose : package term_inject_pkg. It defines the packet header layout and the
//           terminal-count helper. It also holds the destination screening rule
//           used by every injection channel.
// Ports   : none (package)
package term_inject_pkg;

   localparam int NXT_W = 8;
   localparam int ROW_W = 4;
   localparam int COL_W = 4;
   localparam int HDR_W = NXT_W + ROW_W + COL_W + 1;

   // Offsets counted down from the packet MSB: a field's top bit is PCKG_SZ-1-<ofs>.
   localparam int NXT_OFS  = 0;
   localparam int ROW_OFS  = 8;
   localparam int COL_OFS  = 12;
   localparam int MODE_OFS = 16;

   // Header view of the top HDR_W bits of a packet; payload fills the rest.
   typedef struct packed {
      logic [NXT_W-1:0] nxtjp;
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] colum;
      logic             mode;
   } pkt_hdr_t;

   // Contiguous row/colum slice used for screening.
   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] colum;
   } dst_addr_t;

   function automatic int nterm(input int rows, input int colums);
      return 2 * rows + 2 * colums;
   endfunction

   // A destination is a terminal on the mesh rim: top/bottom rows over a real
   // column, or left/right columns beside a real row. Corners are not terminals.
   function automatic logic dst_valid(input logic [ROW_W-1:0] row,
                                      input logic [COL_W-1:0] col,
                                      input int rows, input int colums);
      int   r;
      int   c;
      logic row_in;
      logic col_in;
      r      = int'(row);
      c      = int'(col);
      row_in = (r >= 1) && (r <= rows);
      col_in = (c >= 1) && (c <= colums);
      return (((r == 0) || (r == rows + 1)) && col_in) ||
             (((c == 0) || (c == colums + 1)) && row_in);
   endfunction

endpackage

// File: rtl/term_inject_bank_if.sv
// rtl/term_inject_bank_if.sv - bundled injection-bank signals with traffic-side and bank-side views
//
// Purpose : groups the per-terminal push/pop bus and the drop counters of term_inject_bank.
// Ports   : master = traffic source / mesh side (drives push, push_data, popin, cnt_clr)
//           slave  = the bank (drives full, almost_full, level, pndng, data_out_i_in,
//                    ovf_cnt, bad_dst_cnt)
interface term_inject_bank_if #(
   parameter int NTERM   = 16,
   parameter int PCKG_SZ = 40,
   parameter int LVL_W   = 3,
   parameter int CNT_W   = 16
);
   logic [NTERM-1:0]              push;
   logic [NTERM-1:0][PCKG_SZ-1:0] push_data;
   logic [NTERM-1:0]              full;
   logic [NTERM-1:0]              almost_full;
   logic [NTERM-1:0][LVL_W-1:0]   level;
   logic [NTERM-1:0]              popin;
   logic [NTERM-1:0]              pndng;
   logic [NTERM-1:0][PCKG_SZ-1:0] data_out_i_in;
   logic                          cnt_clr;
   logic [CNT_W-1:0]              ovf_cnt;
   logic [CNT_W-1:0]              bad_dst_cnt;

   modport master (
      output push, push_data, popin, cnt_clr,
      input  full, almost_full, level, pndng, data_out_i_in, ovf_cnt, bad_dst_cnt
   );

   modport slave (
      input  push, push_data, popin, cnt_clr,
      output full, almost_full, level, pndng, data_out_i_in, ovf_cnt, bad_dst_cnt
   );
endinterface

// File: rtl/term_inject_bank_ch.sv
// rtl/term_inject_bank_ch.sv - one show-ahead injection FIFO with destination screening
//
// Purpose : module term_inject_ch, a single terminal channel. It holds the storage
//           array, wrapping pointers and occupancy counter. It decodes the status
//           flags and reports why a push was dropped.
// Ports   : clk, reset (async, active-high)
//           push, push_data            write request / packet
//           popin                      consume head entry
//           full, almost_full, level   occupancy status
//           pndng, data_out            non-empty flag / head entry (0 when empty)
//           drop_ovf, drop_dst         this cycle's push is dropped (full / bad address)
module term_inject_ch
   import term_inject_pkg::*;
#(
   parameter int PCKG_SZ    = 40,
   parameter int FIFO_DEPTH = 4,
   parameter int AF_LEVEL   = 3,
   parameter int ROWS       = 4,
   parameter int COLUMS     = 4,
   parameter int CHECK_DST  = 1,
   parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [PCKG_SZ-1:0] push_data,
   input  logic               popin,
   output logic               full,
   output logic               almost_full,
   output logic [LVL_W-1:0]   level,
   output logic               pndng,
   output logic [PCKG_SZ-1:0] data_out,
   output logic               drop_ovf,
   output logic               drop_dst
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LVL_W-1:0]   count;
   dst_addr_t          addr;
   logic               dst_ok;
   logic               is_empty;
   logic               is_full;
   logic               do_push;
   logic               do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign addr     = dst_addr_t'(push_data[PCKG_SZ-1-ROW_OFS -: ROW_W+COL_W]);
   assign dst_ok   = (CHECK_DST == 0) || dst_valid(addr.row, addr.colum, ROWS, COLUMS);
   assign is_empty = (count == '0);
   assign is_full  = (count == LVL_W'(FIFO_DEPTH));

   // A pop on an empty FIFO is a no-op, so a same-cycle push into an empty
   // FIFO just lands. A pop on a full FIFO frees the slot the push needs.
   assign do_pop   = popin && !is_empty;
   assign do_push  = push && dst_ok && (!is_full || do_pop);
   assign drop_dst = push && !dst_ok;
   assign drop_ovf = push && dst_ok && is_full && !do_pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + LVL_W'(1);
         else if (!do_push && do_pop) count <= count - LVL_W'(1);
      end
   end

   // Storage needs no reset: the head is masked to 0 whenever count is 0.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign full        = is_full;
   assign almost_full = (int'(count) >= AF_LEVEL);
   assign level       = count;
   assign pndng       = !is_empty;
   assign data_out    = is_empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/term_inject_bank.sv
// rtl/term_inject_bank.sv - per-terminal injection FIFO bank with saturating drop counters
//
// Purpose : one term_inject_ch per mesh terminal (2*ROWS + 2*COLUMS). The drop
//           flags of all channels are summed into two saturating counters.
// Ports   : clk, reset (async, active-high)
//           bus (term_inject_bank_if.slave): push/push_data/popin/cnt_clr in;
//           full/almost_full/level/pndng/data_out_i_in/ovf_cnt/bad_dst_cnt out
module term_inject_bank
   import term_inject_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLUMS     = 4,
   parameter int PCKG_SZ    = 40,
   parameter int FIFO_DEPTH = 4,
   parameter int AF_LEVEL   = FIFO_DEPTH - 1,
   parameter int CNT_W      = 16,
   parameter int CHECK_DST  = 1
)(
   input logic              clk,
   input logic              reset,
   term_inject_bank_if.slave bus
);
   localparam int NTERM = nterm(ROWS, COLUMS);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int POP_W = $clog2(NTERM + 1);
   localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

   logic [NTERM-1:0] drop_ovf;
   logic [NTERM-1:0] drop_dst;
   logic [POP_W-1:0] ovf_pop;
   logic [POP_W-1:0] dst_pop;
   logic [CNT_W-1:0] ovf_cnt;
   logic [CNT_W-1:0] bad_dst_cnt;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [POP_W-1:0] inc);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(cnt) + SUM_W'(inc);
      return (sum > SUM_W'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
   endfunction

   for (genvar i = 0; i < NTERM; i++) begin : g_ch
      term_inject_ch #(
         .PCKG_SZ   (PCKG_SZ),
         .FIFO_DEPTH(FIFO_DEPTH),
         .AF_LEVEL  (AF_LEVEL),
         .ROWS      (ROWS),
         .COLUMS    (COLUMS),
         .CHECK_DST (CHECK_DST),
         .LVL_W     (LVL_W)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .push       (bus.push[i]),
         .push_data  (bus.push_data[i]),
         .popin      (bus.popin[i]),
         .full       (bus.full[i]),
         .almost_full(bus.almost_full[i]),
         .level      (bus.level[i]),
         .pndng      (bus.pndng[i]),
         .data_out   (bus.data_out_i_in[i]),
         .drop_ovf   (drop_ovf[i]),
         .drop_dst   (drop_dst[i])
      );
   end

   always_comb begin
      ovf_pop = '0;
      dst_pop = '0;
      for (int i = 0; i < NTERM; i++) begin
         ovf_pop = ovf_pop + POP_W'(drop_ovf[i]);
         dst_pop = dst_pop + POP_W'(drop_dst[i]);
      end
   end

   // Clear has priority over any drops seen in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_cnt     <= '0;
         bad_dst_cnt <= '0;
      end else if (bus.cnt_clr) begin
         ovf_cnt     <= '0;
         bad_dst_cnt <= '0;
      end else begin
         ovf_cnt     <= sat_add(ovf_cnt, ovf_pop);
         bad_dst_cnt <= sat_add(bad_dst_cnt, dst_pop);
      end
   end

   assign bus.ovf_cnt     = ovf_cnt;
   assign bus.bad_dst_cnt = bad_dst_cnt;

endmodule

// File: tb/tb_term_inject_bank.sv
// tb/tb_term_inject_bank.sv - scoreboard bench for term_inject_bank
module tb_term_inject_bank;

   logic                 clk;
   logic                 reset;
   logic [15:0]          push;
   logic [15:0][39:0]    push_data;
   logic [15:0]          popin;
   logic                 cnt_clr;

   int                   n_checks = 0;
   int                   n_fail   = 0;
   logic [39:0]          exp_q [16][$];
   logic [39:0]          exp_val;

   term_inject_bank_if #(.NTERM(16), .PCKG_SZ(40), .LVL_W(3), .CNT_W(16)) if_m ();
   term_inject_bank_if #(.NTERM(16), .PCKG_SZ(40), .LVL_W(3), .CNT_W(16)) if_n ();
   term_inject_bank_if #(.NTERM(16), .PCKG_SZ(40), .LVL_W(3), .CNT_W(4))  if_s ();

   assign if_m.push = push;  assign if_m.push_data = push_data;
   assign if_m.popin = popin; assign if_m.cnt_clr = cnt_clr;
   assign if_n.push = push;  assign if_n.push_data = push_data;
   assign if_n.popin = popin; assign if_n.cnt_clr = cnt_clr;
   assign if_s.push = push;  assign if_s.push_data = push_data;
   assign if_s.popin = popin; assign if_s.cnt_clr = cnt_clr;

   term_inject_bank u_main (.clk(clk), .reset(reset), .bus(if_m));
   term_inject_bank #(.CHECK_DST(0)) u_nodst (.clk(clk), .reset(reset), .bus(if_n));
   term_inject_bank #(.CNT_W(4)) u_sat (.clk(clk), .reset(reset), .bus(if_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no end of test, expected $finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [39:0] pkt(input int row, input int col, input int pay);
      return {8'd0, 4'(row), 4'(col), 1'b1, 23'(pay)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      push    = '0;
      popin   = '0;
      cnt_clr = 1'b0;
   endtask

   // Monitor: every pop the bench requests is checked against the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         for (int c = 0; c < 16; c++) begin
            if (popin[c] && exp_q[c].size() != 0) begin
               exp_val = exp_q[c].pop_front();
               chk($sformatf("pop_pndng_ch%0d", c), 64'(if_m.pndng[c]), 64'd1);
               chk($sformatf("pop_data_ch%0d", c), 64'(if_m.data_out_i_in[c]), 64'(exp_val));
            end else if (popin[c] && if_m.pndng[c]) begin
               n_checks++;
               n_fail++;
               $display("FAIL pop_extra_ch%0d: got head %0h expected empty", c, if_m.data_out_i_in[c]);
            end
         end
      end
   end

   int chs[3] = '{2, 5, 9};

   initial begin
      reset     = 1'b1;
      push      = '0;
      push_data = '0;
      popin     = '0;
      cnt_clr   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pndng", 64'(if_m.pndng), 64'd0);
      chk("rst_full", 64'(if_m.full), 64'd0);
      chk("rst_af", 64'(if_m.almost_full), 64'd0);
      chk("rst_level0", 64'(if_m.level[0]), 64'd0);
      chk("rst_data0", 64'(if_m.data_out_i_in[0]), 64'd0);
      chk("rst_ovf", 64'(if_m.ovf_cnt), 64'd0);
      chk("rst_bad", 64'(if_m.bad_dst_cnt), 64'd0);
      reset = 1'b0;

      // Single packet through ch0.
      push[0] = 1'b1; push_data[0] = 40'h0002800001;
      exp_q[0].push_back(40'h0002800001);
      cyc();
      chk("t1_pndng", 64'(if_m.pndng[0]), 64'd1);
      chk("t1_data", 64'(if_m.data_out_i_in[0]), 64'h0002800001);
      chk("t1_level", 64'(if_m.level[0]), 64'd1);
      popin[0] = 1'b1;
      cyc();
      chk("t1_pndng_after_pop", 64'(if_m.pndng[0]), 64'd0);

      // Destination screening on ch3.
      push[3] = 1'b1; push_data[3] = pkt(5, 5, 11);
      cyc();
      push[3] = 1'b1; push_data[3] = pkt(0, 0, 12);
      cyc();
      chk("t2_level3", 64'(if_m.level[3]), 64'd0);
      chk("t2_pndng3", 64'(if_m.pndng[3]), 64'd0);
      chk("t2_bad", 64'(if_m.bad_dst_cnt), 64'd2);
      chk("t2_bad_sat", 64'(if_s.bad_dst_cnt), 64'd2);
      chk("t2_nodst_level3", 64'(if_n.level[3]), 64'd2);
      push[3] = 1'b1; push_data[3] = pkt(5, 4, 13);
      exp_q[3].push_back(pkt(5, 4, 13));
      cyc();
      chk("t2_rim_level3", 64'(if_m.level[3]), 64'd1);
      chk("t2_rim_bad", 64'(if_m.bad_dst_cnt), 64'd2);
      popin[3] = 1'b1;
      cyc();

      // Fill ch1, overflow, then push-with-pop while full.
      for (int p = 1; p <= 4; p++) begin
         push[1] = 1'b1; push_data[1] = pkt(0, 1, p);
         exp_q[1].push_back(pkt(0, 1, p));
         cyc();
         if (p == 2) chk("t3_af_at2", 64'(if_m.almost_full[1]), 64'd0);
         if (p == 3) chk("t3_af_at3", 64'(if_m.almost_full[1]), 64'd1);
         if (p == 3) chk("t3_full_at3", 64'(if_m.full[1]), 64'd0);
      end
      chk("t3_full", 64'(if_m.full[1]), 64'd1);
      chk("t3_level4", 64'(if_m.level[1]), 64'd4);
      push[1] = 1'b1; push_data[1] = pkt(0, 1, 5);
      cyc();
      chk("t3_ovf", 64'(if_m.ovf_cnt), 64'd1);
      chk("t3_level_after_ovf", 64'(if_m.level[1]), 64'd4);
      push[1] = 1'b1; push_data[1] = pkt(0, 1, 9); popin[1] = 1'b1;
      exp_q[1].push_back(pkt(0, 1, 9));
      cyc();
      chk("t4_level", 64'(if_m.level[1]), 64'd4);
      chk("t4_head", 64'(if_m.data_out_i_in[1]), 64'(pkt(0, 1, 2)));
      chk("t4_ovf_unchanged", 64'(if_m.ovf_cnt), 64'd1);
      for (int p = 0; p < 4; p++) begin
         popin[1] = 1'b1;
         cyc();
      end
      chk("t4_drained", 64'(if_m.pndng[1]), 64'd0);

      // Pop on empty together with push: push lands, level 1.
      push[6] = 1'b1; push_data[6] = pkt(2, 0, 6); popin[6] = 1'b1;
      cyc();
      exp_q[6].push_back(pkt(2, 0, 6));
      chk("t5_empty_pushpop", 64'(if_m.level[6]), 64'd1);
      popin[6] = 1'b1;
      cyc();

      // Multi-channel drops, saturation and clear priority.
      cnt_clr = 1'b1;
      cyc();
      chk("t6_clr_ovf", 64'(if_m.ovf_cnt), 64'd0);
      chk("t6_clr_bad", 64'(if_m.bad_dst_cnt), 64'd0);
      for (int p = 0; p < 4; p++) begin
         foreach (chs[k]) begin
            push[chs[k]] = 1'b1; push_data[chs[k]] = pkt(1, 0, 16 * chs[k] + p);
            exp_q[chs[k]].push_back(pkt(1, 0, 16 * chs[k] + p));
         end
         cyc();
      end
      chk("t6_full3", 64'({if_m.full[9], if_m.full[5], if_m.full[2]}), 64'd7);
      for (int d = 1; d <= 6; d++) begin
         foreach (chs[k]) begin
            push[chs[k]] = 1'b1; push_data[chs[k]] = pkt(1, 5, 99);
         end
         if (d == 6) begin
            push[4] = 1'b1; push_data[4] = pkt(0, 5, 1);
         end
         cyc();
         if (d == 1) chk("t6_ovf3", 64'(if_m.ovf_cnt), 64'd3);
         if (d == 1) chk("t6_ovf3_sat", 64'(if_s.ovf_cnt), 64'd3);
         if (d == 5) chk("t6_ovf15", 64'(if_m.ovf_cnt), 64'd15);
         if (d == 5) chk("t6_ovf15_sat", 64'(if_s.ovf_cnt), 64'd15);
         if (d == 6) chk("t6_ovf18", 64'(if_m.ovf_cnt), 64'd18);
         if (d == 6) chk("t6_saturated", 64'(if_s.ovf_cnt), 64'd15);
         if (d == 6) chk("t6_bad1", 64'(if_m.bad_dst_cnt), 64'd1);
      end
      foreach (chs[k]) begin
         push[chs[k]] = 1'b1; push_data[chs[k]] = pkt(1, 5, 98);
      end
      push[4] = 1'b1; push_data[4] = pkt(0, 5, 2);
      cnt_clr = 1'b1;
      cyc();
      chk("t6_clrwin_ovf", 64'(if_m.ovf_cnt), 64'd0);
      chk("t6_clrwin_bad", 64'(if_m.bad_dst_cnt), 64'd0);
      chk("t6_clrwin_sat", 64'(if_s.ovf_cnt), 64'd0);
      for (int p = 0; p < 4; p++) begin
         foreach (chs[k]) popin[chs[k]] = 1'b1;
         cyc();
      end

      // Asynchronous reset in the middle of traffic.
      for (int p = 0; p < 3; p++) begin
         push[0] = 1'b1; push_data[0] = pkt(0, 4, 40 + p);
         exp_q[0].push_back(pkt(0, 4, 40 + p));
         cyc();
      end
      chk("t7_level3", 64'(if_m.level[0]), 64'd3);
      #2;
      reset = 1'b1;
      #1;
      exp_q[0].delete();
      chk("t7_rst_pndng", 64'(if_m.pndng), 64'd0);
      chk("t7_rst_level0", 64'(if_m.level[0]), 64'd0);
      chk("t7_rst_data0", 64'(if_m.data_out_i_in[0]), 64'd0);
      chk("t7_rst_af", 64'(if_m.almost_full), 64'd0);
      #3;
      reset = 1'b0;
      push[0] = 1'b1; push_data[0] = pkt(0, 3, 77);
      exp_q[0].push_back(pkt(0, 3, 77));
      cyc();
      chk("t7_post_level", 64'(if_m.level[0]), 64'd1);
      chk("t7_post_data", 64'(if_m.data_out_i_in[0]), 64'(pkt(0, 3, 77)));
      popin[0] = 1'b1;
      cyc();
      cyc();

      for (int c = 0; c < 16; c++) begin
         chk($sformatf("end_queue_ch%0d", c), 64'(exp_q[c].size()), 64'd0);
      end
      chk("end_pndng", 64'(if_m.pndng), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/term_inject_bank.md
# term_inject_bank

Synthesizable multi-terminal injection buffer bank for the `mesh_gnrtr` router mesh. It provides one show-ahead FIFO per mesh terminal, `NTERM = 2*ROWS + 2*COLUMS` terminals in all. Each FIFO presents `pndng`/`data_out_i_in` to the mesh and consumes the mesh's `popin`. It is the parametrised RTL successor of the per-terminal behavioural input FIFO. It adds almost-full signalling, destination-address screening, and saturating drop counters, so benches and future traffic generators get a cycle-accurate, checkable source.

## Interface
Parameters:
- `ROWS`, 4, mesh rows.
- `COLUMS`, 4, mesh columns.
- `PCKG_SZ`, 40, packet width in bits (≥ 18).
- `FIFO_DEPTH`, 4, entries per channel (≥ 2; need not be a power of two).
- `AF_LEVEL`, `FIFO_DEPTH-1`, occupancy at or above which `almost_full` asserts.
- `CNT_W`, 16, drop-counter width.
- `CHECK_DST`, 1, enables destination screening (0 = accept all).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all state cleared immediately.
- `push`  in  `[NTERM-1:0]`  per-channel write request.
- `push_data`  in  `[NTERM-1:0][PCKG_SZ-1:0]`  per-channel write packet.
- `full`  out  `[NTERM-1:0]`  occupancy == `FIFO_DEPTH`.
- `almost_full`  out  `[NTERM-1:0]`  occupancy ≥ `AF_LEVEL`.
- `level`  out  `[NTERM-1:0][$clog2(FIFO_DEPTH+1)-1:0]`  current occupancy.
- `popin`  in  `[NTERM-1:0]`  mesh consumes head entry.
- `pndng`  out  `[NTERM-1:0]`  channel non-empty.
- `data_out_i_in`  out  `[NTERM-1:0][PCKG_SZ-1:0]`  head entry (show-ahead).
- `cnt_clr`  in  1  synchronous clear of both counters.
- `ovf_cnt`  out  `CNT_W`  packets dropped because the channel was full.
- `bad_dst_cnt`  out  `CNT_W`  packets dropped for an invalid destination.

## Operation
- Packet fields:
  - `[PCKG_SZ-1:PCKG_SZ-8]` Nxtjp.
  - `[PCKG_SZ-9:PCKG_SZ-12]` row.
  - `[PCKG_SZ-13:PCKG_SZ-16]` colum.
  - `[PCKG_SZ-17]` mode.
  - Remaining low bits are payload.
  - Stored and emitted unmodified.
- Valid destination, evaluated when `CHECK_DST=1`: (row==0 or row==ROWS+1) with 1≤col≤COLUMS, or (col==0 or col==COLUMS+1) with 1≤row≤ROWS. Corners and anything outside this set are invalid.
- Per channel, per cycle, the push outcome is exactly one of:
  - Invalid destination: dropped; counts toward `bad_dst_cnt` regardless of space.
  - Full with no same-cycle pop: dropped; counts toward `ovf_cnt`.
  - Otherwise: written at the tail.
- Push while full together with `popin` in the same cycle: accepted; occupancy unchanged.
- `popin` while empty: ignored; no pointer movement, no error.
- Push and pop on an empty FIFO in the same cycle: the pop is ignored and the push is written; occupancy becomes 1.
- Pointers wrap from `FIFO_DEPTH-1` to 0.
- Counters:
  - Each cycle, each counter adds the popcount of that cycle's drops across all channels.
  - Counters saturate at all-ones.
  - `cnt_clr` wins over same-cycle increments; the result is 0.

## Timing
- Reset values: `pndng`=0, `full`=0, `almost_full`=0 (1 if `AF_LEVEL`==0), `level`=0, `data_out_i_in`=0, `ovf_cnt`=0, `bad_dst_cnt`=0.
- Push to `pndng`/`data_out_i_in` valid: 1 cycle. Data is written at edge N and visible after edge N.
- `popin` sampled at edge N; the next entry is presented after edge N. Effective 1-cycle pop-to-next-head.
- `full`, `almost_full`, `level` and `pndng` are registered-state decodes and update after the edge that changes occupancy.
- Counters update 1 cycle after the offending push edge.
- Reset asserted mid-traffic: all FIFOs empty and outputs at reset values without waiting for a clock edge. First push accepted on the first rising edge after deassertion.

## Structure
- Package `term_inject_pkg`:
  - Field offset constants.
  - `NTERM` function.
  - `dst_valid(row, col, ROWS, COLUMS)` function.
  - Packet struct view.
- Sub-module `term_inject_ch`:
  - One channel: storage array, wrap pointers, occupancy counter, full/almost-full/pndng decode, drop-reason outputs.
  - Instantiated `NTERM` times via generate.
- Top level: counter popcount/saturation logic and port packing only.

## Test plan
- Push {Nxtjp=0,row=0,col=2,mode=1,payload=1} on ch0 → after 1 cycle `pndng[0]`=1, `data_out_i_in[0]` equals the packet, `level[0]`=1; `popin[0]` → `pndng[0]`=0.
- Push row=5,col=5 on ch3, then row=0,col=0 on ch3 → FIFO stays empty; `bad_dst_cnt`=2; with `CHECK_DST=0`, both accepted.
- Push 4 packets (payload 1..4) on ch1, then a 5th → `full[1]`=1, `almost_full[1]` from level 3, `ovf_cnt`=1. Pops return 1,2,3,4 in order.
- Ch1 full; push payload 9 with `popin[1]` in the same cycle → `level[1]` stays 4; head becomes 2; 9 is last out.
- Ch2, ch5, ch9 full; push on all three in one cycle → `ovf_cnt` +3. Preload the counter near all-ones (`CNT_W`=4) → it saturates at 15. `cnt_clr` in the same cycle as a drop → 0.
- Fill ch0 with 3 packets, assert `reset` between edges → all outputs at reset values immediately; the first post-reset push appears after 1 cycle with `level[0]`=1.
